// File: rtl/jtag_l2_test.sv
// JTAG TAP giving debug read/write access to a small L2 word memory across the TCK/clk_i boundary.
// Latency: a request completes 2 clk_i sync + 1 clk_i access + 2 TCK sync cycles after its Update-DR.
// Backpressure: one request in flight; a request launched while busy is dropped, RDATA valid=0 shows busy.
//
// Ports:
//   clk_i, rst_i       system clock / async active-high reset of the clk_i-side engine
//   jtag_tck_i         JTAG test clock (TAP serial logic only)
//   jtag_trst_ni       async active-low TAP reset
//   jtag_tms_i/tdi_i   TMS/TDI, sampled on TCK rising edge
//   jtag_tdo_o         TDO, changes on TCK falling edge, 0 outside Shift-IR/Shift-DR
module jtag_l2_test #(
    parameter logic [31:0] IDCODE_VAL = 32'h2495_11C3,
    parameter int          MEM_WORDS  = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic jtag_tck_i,
    input  logic jtag_trst_ni,
    input  logic jtag_tms_i,
    input  logic jtag_tdi_i,
    output logic jtag_tdo_o
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [4:0] IR_IDCODE  = 5'h02;
    localparam logic [4:0] IR_CONFREG = 5'h06;
    localparam logic [4:0] IR_ADDR    = 5'h08;
    localparam logic [4:0] IR_WDATA   = 5'h09;
    localparam logic [4:0] IR_RDATA   = 5'h0A;

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_t;

    typedef enum logic [2:0] {
        DR_BYPASS, DR_IDCODE, DR_CONF, DR_ADDR, DR_WDATA, DR_RDATA
    } dr_sel_t;

    // Request payload handed across the crossing; held stable until acked.
    typedef struct packed {
        logic          wr;
        logic          en;
        logic [AW-1:0] idx;
        logic [31:0]   wdata;
    } req_t;

    tap_state_t  tap_state;
    dr_sel_t     dr_sel;
    logic [4:0]  ir_sr;
    logic [4:0]  ir_q;
    logic [32:0] dr_sr;
    logic [8:0]  conf_q;
    logic [31:0] addr_q;
    logic        req_tgl;
    req_t        req_q;
    logic        ack_s1;
    logic        ack_s2;
    logic        busy;
    logic        acc_en;
    logic        tdo_q;

    logic        req_s1;
    logic        req_s2;
    logic        ack_q;
    logic        go;
    logic [31:0] rdata_q;
    logic [31:0] mem [MEM_WORDS];

    // ------------------------------------------------------------------
    // TAP controller
    // ------------------------------------------------------------------
    always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
        if (!jtag_trst_ni) begin
            tap_state <= TLR;
        end else begin
            unique case (tap_state)
                TLR:    tap_state <= jtag_tms_i ? TLR    : RTI;
                RTI:    tap_state <= jtag_tms_i ? SEL_DR : RTI;
                SEL_DR: tap_state <= jtag_tms_i ? SEL_IR : CAP_DR;
                CAP_DR: tap_state <= jtag_tms_i ? EX1_DR : SH_DR;
                SH_DR:  tap_state <= jtag_tms_i ? EX1_DR : SH_DR;
                EX1_DR: tap_state <= jtag_tms_i ? UPD_DR : PAU_DR;
                PAU_DR: tap_state <= jtag_tms_i ? EX2_DR : PAU_DR;
                EX2_DR: tap_state <= jtag_tms_i ? UPD_DR : SH_DR;
                UPD_DR: tap_state <= jtag_tms_i ? SEL_DR : RTI;
                SEL_IR: tap_state <= jtag_tms_i ? TLR    : CAP_IR;
                CAP_IR: tap_state <= jtag_tms_i ? EX1_IR : SH_IR;
                SH_IR:  tap_state <= jtag_tms_i ? EX1_IR : SH_IR;
                EX1_IR: tap_state <= jtag_tms_i ? UPD_IR : PAU_IR;
                PAU_IR: tap_state <= jtag_tms_i ? EX2_IR : PAU_IR;
                EX2_IR: tap_state <= jtag_tms_i ? UPD_IR : SH_IR;
                UPD_IR: tap_state <= jtag_tms_i ? SEL_DR : RTI;
            endcase
        end
    end

    // Instruction decode; unknown codes fall through to BYPASS.
    always_comb begin
        dr_sel = DR_BYPASS;
        case (ir_q)
            IR_IDCODE:  dr_sel = DR_IDCODE;
            IR_CONFREG: dr_sel = DR_CONF;
            IR_ADDR:    dr_sel = DR_ADDR;
            IR_WDATA:   dr_sel = DR_WDATA;
            IR_RDATA:   dr_sel = DR_RDATA;
            default:    dr_sel = DR_BYPASS;
        endcase
    end

    assign busy   = (req_tgl != ack_s2);
    assign acc_en = (conf_q[3:1] == 3'b001);

    // ------------------------------------------------------------------
    // IR / DR capture-shift-update, request launch
    // ------------------------------------------------------------------
    always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
        if (!jtag_trst_ni) begin
            ir_sr   <= 5'b00001;
            ir_q    <= IR_IDCODE;
            dr_sr   <= '0;
            conf_q  <= '0;
            addr_q  <= '0;
            req_tgl <= 1'b0;
            req_q   <= '0;
        end else begin
            case (tap_state)
                TLR:    ir_q  <= IR_IDCODE;
                CAP_IR: ir_sr <= 5'b00001;
                SH_IR:  ir_sr <= {jtag_tdi_i, ir_sr[4:1]};
                UPD_IR: ir_q  <= ir_sr;
                CAP_DR: begin
                    case (dr_sel)
                        DR_IDCODE: dr_sr <= {1'b0, IDCODE_VAL};
                        DR_CONF:   dr_sr <= {24'b0, conf_q};
                        DR_ADDR:   dr_sr <= {1'b0, addr_q};
                        DR_WDATA:  dr_sr <= {1'b0, req_q.wdata};
                        DR_RDATA:  dr_sr <= {~busy, rdata_q};
                        default:   dr_sr <= '0;
                    endcase
                end
                // TDI enters at the MSB of the selected register length.
                SH_DR: begin
                    case (dr_sel)
                        DR_IDCODE,
                        DR_ADDR,
                        DR_WDATA: dr_sr <= {1'b0, jtag_tdi_i, dr_sr[31:1]};
                        DR_CONF:  dr_sr <= {24'b0, jtag_tdi_i, dr_sr[8:1]};
                        DR_RDATA: dr_sr <= {jtag_tdi_i, dr_sr[32:1]};
                        default:  dr_sr <= {32'b0, jtag_tdi_i};
                    endcase
                end
                UPD_DR: begin
                    case (dr_sel)
                        DR_CONF: conf_q <= dr_sr[8:0];
                        DR_ADDR: begin
                            addr_q <= dr_sr[31:0];
                            if (!busy) begin
                                req_tgl   <= ~req_tgl;
                                req_q.wr  <= 1'b0;
                                req_q.en  <= acc_en;
                                req_q.idx <= dr_sr[AW+1:2];
                            end
                        end
                        DR_WDATA: begin
                            if (!busy) begin
                                req_tgl     <= ~req_tgl;
                                req_q.wr    <= 1'b1;
                                req_q.en    <= acc_en;
                                req_q.idx   <= addr_q[AW+1:2];
                                req_q.wdata <= dr_sr[31:0];
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Ack synchronizer back into TCK.
    always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
        if (!jtag_trst_ni) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            ack_s1 <= ack_q;
            ack_s2 <= ack_s1;
        end
    end

    always_ff @(negedge jtag_tck_i or negedge jtag_trst_ni) begin
        if (!jtag_trst_ni) begin
            tdo_q <= 1'b0;
        end else if (tap_state == SH_IR) begin
            tdo_q <= ir_sr[0];
        end else if (tap_state == SH_DR) begin
            tdo_q <= dr_sr[0];
        end else begin
            tdo_q <= 1'b0;
        end
    end

    assign jtag_tdo_o = tdo_q;

    // ------------------------------------------------------------------
    // clk_i side: request synchronizer and single-cycle access engine.
    // A toggle that arrives while rst_i is held stays pending in req_tgl
    // and is picked up exactly once after release.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_s1 <= 1'b0;
            req_s2 <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            req_s1 <= req_tgl;
            req_s2 <= req_s1;
            if (go) begin
                ack_q <= ~ack_q;
            end
        end
    end

    assign go = (req_s2 != ack_q);

    // Memory has no reset; disabled writes are dropped.
    always_ff @(posedge clk_i) begin
        if (go && req_q.wr && req_q.en) begin
            mem[req_q.idx] <= req_q.wdata;
        end
    end

    // Read result is owned by the TAP reset so a debugger sees a clean 0.
    always_ff @(posedge clk_i or negedge jtag_trst_ni) begin
        if (!jtag_trst_ni) begin
            rdata_q <= '0;
        end else if (go && !req_q.wr) begin
            rdata_q <= req_q.en ? mem[req_q.idx] : 32'h0;
        end
    end

endmodule

// File: tb/tb_jtag_l2_test.sv
// Directed bench for jtag_l2_test: drives TCK by hand, uses a slow clk_i so
// a freshly launched request is still in flight during the following scan.
module tb_jtag_l2_test;

    logic clk_i;
    logic rst_i;
    logic jtag_tck;
    logic jtag_trst_n;
    logic jtag_tms;
    logic jtag_tdi;
    logic jtag_tdo;

    int checks;
    int failures;

    jtag_l2_test #(
        .IDCODE_VAL(32'h2495_11C3),
        .MEM_WORDS (256)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .jtag_tck_i  (jtag_tck),
        .jtag_trst_ni(jtag_trst_n),
        .jtag_tms_i  (jtag_tms),
        .jtag_tdi_i  (jtag_tdi),
        .jtag_tdo_o  (jtag_tdo)
    );

    initial begin
        clk_i = 1'b0;
        forever #100 clk_i = ~clk_i;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // One TCK period; TDO is sampled mid low phase, just before the rising edge.
    task automatic tick(input logic tms, input logic tdi, output logic tdo_s);
        jtag_tms = tms;
        jtag_tdi = tdi;
        #5;
        tdo_s = jtag_tdo;
        jtag_tck = 1'b1;
        #5;
        jtag_tck = 1'b0;
    endtask

    task automatic idle(input int n);
        logic o;
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, o);
    endtask

    // Both scans start and end in Run-Test/Idle.
    task automatic scan_ir(input logic [4:0] val, output logic [4:0] out);
        logic o;
        tick(1'b1, 1'b0, o);
        tick(1'b1, 1'b0, o);
        tick(1'b0, 1'b0, o);
        tick(1'b0, 1'b0, o);
        for (int i = 0; i < 5; i++) begin
            tick(i == 4, val[i], o);
            out[i] = o;
        end
        tick(1'b1, 1'b0, o);
        tick(1'b0, 1'b0, o);
    endtask

    task automatic scan_dr(input logic [32:0] val, input int len, output logic [32:0] out);
        logic o;
        out = '0;
        tick(1'b1, 1'b0, o);
        tick(1'b0, 1'b0, o);
        tick(1'b0, 1'b0, o);
        for (int i = 0; i < len; i++) begin
            tick(i == len - 1, val[i], o);
            out[i] = o;
        end
        tick(1'b1, 1'b0, o);
        tick(1'b0, 1'b0, o);
    endtask

    logic [4:0]  ir_out;
    logic [32:0] dr_out;
    logic        o;

    initial begin
        checks      = 0;
        failures    = 0;
        jtag_tck    = 1'b0;
        jtag_tms    = 1'b1;
        jtag_tdi    = 1'b0;
        jtag_trst_n = 1'b0;
        rst_i       = 1'b1;
        #20;
        chk_eq("rst_tdo", {63'b0, jtag_tdo}, 64'h0);
        jtag_trst_n = 1'b1;
        #250;
        rst_i = 1'b0;
        tick(1'b0, 1'b0, o);

        // IR defaults to IDCODE out of reset
        scan_dr(33'h0, 32, dr_out);
        chk_eq("idcode", {31'b0, dr_out}, 64'h2495_11C3);
        scan_ir(5'h1F, ir_out);
        chk_eq("ir_capture", {59'b0, ir_out}, 64'h01);
        tick(1'b0, 1'b0, o);
        chk_eq("tdo_idle", {63'b0, o}, 64'h0);

        // BYPASS: 9 shifts, first out bit is the captured 0
        scan_dr({25'b0, 8'hA5}, 9, dr_out);
        chk_eq("bypass_cap", {63'b0, dr_out[0]}, 64'h0);
        chk_eq("bypass", {56'b0, dr_out[8:1]}, 64'hA5);

        // Five TMS=1 clocks reach Test-Logic-Reset and restore IDCODE
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, o);
        tick(1'b0, 1'b0, o);
        scan_dr(33'h0, 32, dr_out);
        chk_eq("tlr_idcode", {31'b0, dr_out}, 64'h2495_11C3);

        // CONFREG write and readback
        scan_ir(5'h06, ir_out);
        scan_dr(33'h002, 9, dr_out);
        chk_eq("conf_rst", {31'b0, dr_out}, 64'h0);
        scan_dr(33'h002, 9, dr_out);
        chk_eq("conf_rb", {31'b0, dr_out}, 64'h002);

        // Enabled write then read of word 0
        scan_ir(5'h08, ir_out);
        scan_dr(33'h0, 32, dr_out);
        idle(100);
        scan_ir(5'h09, ir_out);
        scan_dr(33'hABBA_ABBA, 32, dr_out);
        idle(100);
        scan_ir(5'h08, ir_out);
        scan_dr(33'h0, 32, dr_out);
        idle(100);
        scan_ir(5'h0A, ir_out);
        scan_dr(33'h0, 33, dr_out);
        chk_eq("rd_abba", {31'b0, dr_out}, 64'h1_ABBA_ABBA);

        // 0x400 wraps to word 0; RDATA right after launch shows busy
        scan_ir(5'h08, ir_out);
        scan_dr(33'h400, 32, dr_out);
        scan_ir(5'h0A, ir_out);
        scan_dr(33'h0, 33, dr_out);
        chk_eq("rd_busy", {63'b0, dr_out[32]}, 64'h0);
        idle(100);
        scan_dr(33'h0, 33, dr_out);
        chk_eq("rd_wrap", {31'b0, dr_out}, 64'h1_ABBA_ABBA);

        // Seed word 1, then disabled write/read must not touch it
        scan_ir(5'h08, ir_out);
        scan_dr(33'h4, 32, dr_out);
        idle(100);
        scan_ir(5'h09, ir_out);
        scan_dr(33'hCAFE_F00D, 32, dr_out);
        idle(100);
        scan_ir(5'h06, ir_out);
        scan_dr(33'h0, 9, dr_out);
        scan_ir(5'h08, ir_out);
        scan_dr(33'h4, 32, dr_out);
        chk_eq("addr_cap", {31'b0, dr_out}, 64'h4);
        idle(100);
        scan_ir(5'h09, ir_out);
        scan_dr(33'h1234_5678, 32, dr_out);
        idle(100);
        scan_ir(5'h08, ir_out);
        scan_dr(33'h4, 32, dr_out);
        idle(100);
        scan_ir(5'h0A, ir_out);
        scan_dr(33'h0, 33, dr_out);
        chk_eq("rd_dis", {31'b0, dr_out}, 64'h1_0000_0000);
        scan_ir(5'h06, ir_out);
        scan_dr(33'h002, 9, dr_out);
        scan_ir(5'h08, ir_out);
        scan_dr(33'h4, 32, dr_out);
        idle(100);
        scan_ir(5'h0A, ir_out);
        scan_dr(33'h0, 33, dr_out);
        chk_eq("rd_keep", {31'b0, dr_out}, 64'h1_CAFE_F00D);

        // Ten launches so far, so the request toggle sits at 0 here.
        // A request issued under rst_i waits, then executes on release.
        rst_i = 1'b1;
        idle(40);
        scan_ir(5'h06, ir_out);
        scan_dr(33'h002, 9, dr_out);
        chk_eq("conf_rst_i", {31'b0, dr_out}, 64'h002);
        scan_ir(5'h08, ir_out);
        scan_dr(33'h0, 32, dr_out);
        idle(100);
        scan_ir(5'h0A, ir_out);
        scan_dr(33'h0, 33, dr_out);
        chk_eq("rst_hold", {63'b0, dr_out[32]}, 64'h0);
        rst_i = 1'b0;
        idle(100);
        scan_dr(33'h0, 33, dr_out);
        chk_eq("rst_exec", {31'b0, dr_out}, 64'h1_ABBA_ABBA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
